// File: rtl/riscv_pkg.sv
// RV32I(+M) decode table: opcode/funct constants, control-code encodings,
// the control bundle type and the pure decode function.
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_ADD  = 4'b1000;
  localparam logic [3:0] ALU_SUB  = 4'b1100;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_EQ   = 3'b001;
  localparam logic [2:0] BR_NE   = 3'b010;
  localparam logic [2:0] BR_LT   = 3'b011;
  localparam logic [2:0] BR_GE   = 3'b100;
  localparam logic [2:0] BR_LTU  = 3'b101;
  localparam logic [2:0] BR_GEU  = 3'b110;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_B    = 3'b001;
  localparam logic [2:0] LD_H    = 3'b010;
  localparam logic [2:0] LD_W    = 3'b011;
  localparam logic [2:0] LD_BU   = 3'b100;
  localparam logic [2:0] LD_HU   = 3'b101;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_B    = 2'b01;
  localparam logic [1:0] ST_H    = 2'b10;
  localparam logic [1:0] ST_W    = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MD  = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;
  localparam logic [1:0] WB_PC4 = 2'b11;

  localparam logic [1:0] A_RS1  = 2'b00;
  localparam logic [1:0] A_PC   = 2'b01;
  localparam logic [1:0] A_ZERO = 2'b10;

  localparam logic [1:0] B_RS2  = 2'b00;
  localparam logic [1:0] B_IMM  = 2'b01;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        reg_write;
    logic [1:0]  memtoreg;
    logic [1:0]  st_cntr;
    logic [2:0]  ld_cntr;
    logic [1:0]  alu_a;
    logic [1:0]  alu_b;
    logic [3:0]  alu_cntr;
    logic [31:0] imm;
    logic [2:0]  branch_cntr;
    logic        jal;
    logic        jalr;
    logic        md_op;
    logic [2:0]  md_funct;
    logic        illegal;
  } ctrl_t;

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt, input logic is_reg);
    logic [3:0] a;
    case (f3)
      F3_ADD:  a = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:  a = ALU_SLL;
      F3_SLT:  a = ALU_SLT;
      F3_SLTU: a = ALU_SLTU;
      F3_XOR:  a = ALU_XOR;
      F3_SR:   a = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   a = ALU_OR;
      default: a = ALU_AND;
    endcase
    return a;
  endfunction

  function automatic ctrl_t decode(input logic [31:0] instr, input logic m_ext);
    ctrl_t c;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    c = '0;
    op = instr[6:0];
    f3 = instr[14:12];
    f7 = instr[31:25];
    c.rd  = instr[11:7];
    c.rs1 = instr[19:15];
    c.rs2 = instr[24:20];
    case (op)
      OP_LUI, OP_AUIPC: begin
        c.reg_write = 1'b1;
        c.alu_a     = (op == OP_LUI) ? A_ZERO : A_PC;
        c.alu_b     = B_IMM;
        c.alu_cntr  = ALU_ADD;
        c.imm       = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        c.reg_write = 1'b1;
        c.jal       = 1'b1;
        c.memtoreg  = WB_PC4;
        c.alu_a     = A_PC;
        c.alu_b     = B_IMM;
        c.alu_cntr  = ALU_ADD;
        c.imm       = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_JALR: begin
        c.reg_write = 1'b1;
        c.jalr      = 1'b1;
        c.memtoreg  = WB_PC4;
        c.alu_b     = B_IMM;
        c.alu_cntr  = ALU_ADD;
        c.imm       = {{20{instr[31]}}, instr[31:20]};
      end
      OP_BRANCH: begin
        c.alu_cntr = ALU_SUB;
        c.imm      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        case (f3)
          3'b000:  c.branch_cntr = BR_EQ;
          3'b001:  c.branch_cntr = BR_NE;
          3'b100:  c.branch_cntr = BR_LT;
          3'b101:  c.branch_cntr = BR_GE;
          3'b110:  c.branch_cntr = BR_LTU;
          3'b111:  c.branch_cntr = BR_GEU;
          default: c.illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        c.reg_write = 1'b1;
        c.memtoreg  = WB_MEM;
        c.alu_b     = B_IMM;
        c.alu_cntr  = ALU_ADD;
        c.imm       = {{20{instr[31]}}, instr[31:20]};
        case (f3)
          3'b000:  c.ld_cntr = LD_B;
          3'b001:  c.ld_cntr = LD_H;
          3'b010:  c.ld_cntr = LD_W;
          3'b100:  c.ld_cntr = LD_BU;
          3'b101:  c.ld_cntr = LD_HU;
          default: c.illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        c.alu_b    = B_IMM;
        c.alu_cntr = ALU_ADD;
        c.imm      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        case (f3)
          3'b000:  c.st_cntr = ST_B;
          3'b001:  c.st_cntr = ST_H;
          3'b010:  c.st_cntr = ST_W;
          default: c.illegal = 1'b1;
        endcase
      end
      OP_IMM: begin
        c.reg_write = 1'b1;
        c.alu_b     = B_IMM;
        c.alu_cntr  = alu_of(f3, instr[30], 1'b0);
        c.imm       = (f3 == F3_SLL || f3 == F3_SR) ? {27'b0, instr[24:20]}
                                                    : {{20{instr[31]}}, instr[31:20]};
      end
      OP_REG: begin
        if (f7 == F7_MUL) begin
          if (m_ext) begin
            c.md_op     = 1'b1;
            c.md_funct  = f3;
            c.reg_write = 1'b1;
            c.memtoreg  = WB_MD;
            c.alu_cntr  = ALU_NONE;
          end else begin
            c.illegal = 1'b1;
          end
        end else begin
          c.reg_write = 1'b1;
          c.alu_cntr  = alu_of(f3, (f7 == F7_ALT), 1'b1);
        end
      end
      default: c.illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) c.illegal = 1'b1;
    if (c.illegal) begin
      c.reg_write   = 1'b0;
      c.st_cntr     = ST_NONE;
      c.branch_cntr = BR_NONE;
      c.jal         = 1'b0;
      c.jalr        = 1'b0;
      c.md_op       = 1'b0;
      c.imm         = '0;
    end
    return c;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Power-of-2 circular instruction queue with occupancy count and flush.
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  // Storage array; no reset needed, entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Buffered RV32 decode stage: instruction queue, bypass path and a
// registered control bundle with its own valid/ready handshake.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned M_EXT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [PC_W-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [4:0]             rd,
  output logic [4:0]             rs1,
  output logic [4:0]             rs2,
  output logic                   reg_write,
  output logic [1:0]             memtoreg,
  output logic [1:0]             st_cntr,
  output logic [2:0]             ld_cntr,
  output logic [1:0]             alu_a,
  output logic [1:0]             alu_b,
  output logic [3:0]             alu_cntr,
  output logic [31:0]            imm,
  output logic [2:0]             branch_cntr,
  output logic                   jal,
  output logic                   jalr,
  output logic                   md_op,
  output logic [2:0]             md_funct,
  output logic                   illegal,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned W = 32 + PC_W;

  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic [W-1:0]    head;
  logic            load;
  logic            accept;
  logic            bypass;
  logic            have_src;
  logic [31:0]     src_instr;
  logic [PC_W-1:0] src_pc;
  ctrl_t           dec;
  ctrl_t           ctrl_q;
  logic [PC_W-1:0] pc_q;

  instr_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (fifo_push),
    .wdata ({in_instr, in_pc}),
    .pop   (fifo_pop),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Output register advances when empty or being drained. The queue head
  // has priority; an empty queue lets the incoming word skip straight in.
  assign in_ready  = !rst && !fifo_full;
  assign load      = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign bypass    = load && fifo_empty && accept;
  assign fifo_push = accept && !bypass;
  assign fifo_pop  = load && !fifo_empty;
  assign have_src  = !fifo_empty || accept;
  assign src_instr = fifo_empty ? in_instr : head[W-1:PC_W];
  assign src_pc    = fifo_empty ? in_pc    : head[PC_W-1:0];
  assign dec       = decode(src_instr, (M_EXT != 0));

  // Registered control bundle; flush and reset clear it outright.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      pc_q      <= '0;
    end else if (load) begin
      out_valid <= have_src;
      if (have_src) begin
        ctrl_q <= dec;
        pc_q   <= src_pc;
      end
    end
  end

  assign out_pc      = pc_q;
  assign rd          = ctrl_q.rd;
  assign rs1         = ctrl_q.rs1;
  assign rs2         = ctrl_q.rs2;
  assign reg_write   = ctrl_q.reg_write;
  assign memtoreg    = ctrl_q.memtoreg;
  assign st_cntr     = ctrl_q.st_cntr;
  assign ld_cntr     = ctrl_q.ld_cntr;
  assign alu_a       = ctrl_q.alu_a;
  assign alu_b       = ctrl_q.alu_b;
  assign alu_cntr    = ctrl_q.alu_cntr;
  assign imm         = ctrl_q.imm;
  assign branch_cntr = ctrl_q.branch_cntr;
  assign jal         = ctrl_q.jal;
  assign jalr        = ctrl_q.jalr;
  assign md_op       = ctrl_q.md_op;
  assign md_funct    = ctrl_q.md_funct;
  assign illegal     = ctrl_q.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, buffered RV32 decode stage that supersedes the combinational decoder in the core pipeline.
- Accepts fetched instructions through a valid/ready interface into a DEPTH-entry instruction queue.
- Decodes the queue head with the team decode table, which lives in riscv_pkg.
- Presents a registered control bundle to execute, under its own valid/ready handshake.
- Adds two behaviours the old decoder lacked: optional M-extension decode and illegal-instruction detection.

Parameters:
- DEPTH, 4: instruction queue entries; a power of 2, at least 2.
- PC_W, 32: width of the program-counter field carried alongside each instruction.
- M_EXT, 1: when 1, MUL/DIV decode is enabled; when 0, any funct7=0000001 R-type instruction is flagged illegal.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all queued and registered instructions (taken branch or trap)
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  = !queue_full
- in_instr  in  32  instruction word
- in_pc  in  PC_W  address of in_instr
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts the bundle
- out_pc  out  PC_W  PC of the decoded instruction
- rd, rs1, rs2  out  5 each  register fields
- reg_write  out  1  writeback enable
- memtoreg  out  2  writeback source select
- st_cntr  out  2  store size control
- ld_cntr  out  3  load size/sign control
- alu_a, alu_b  out  2 each  ALU operand selects
- alu_cntr  out  4  ALU operation
- imm  out  32  decoded immediate
- branch_cntr  out  3  branch condition
- jal, jalr  out  1 each  jump flags
- md_op  out  1  mul/div instruction
- md_funct  out  3  mul/div operation (funct3)
- illegal  out  1  undecodable instruction
- count  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset (rst=1 at a clk edge):
  - Queue pointers and count go to 0.
  - out_valid and every decoded output go to 0.
  - in_ready is 0 while rst is high and 1 in the first cycle after reset.
  - Reset mid-transfer drops all in-flight instructions; nothing partial is ever emitted.
- Push: in_valid && in_ready writes {in_instr, in_pc} at the write pointer. Pointers wrap modulo DEPTH.
- Output register load: the register loads when (!out_valid || out_ready).
  - Source is the queue head if the queue is non-empty.
  - Otherwise the push data is loaded directly (bypass).
  - Bypass latency is 1 cycle: an instruction accepted in cycle N is visible on out_* in cycle N+1.
  - The queue path adds 1 cycle per queued predecessor.
- out_* hold stable while out_valid && !out_ready. out_valid falls only on acceptance with no next source.
- Occupancy rules:
  - Push and pop in the same cycle leave count unchanged.
  - With the queue full, in_ready=0 and no push occurs, even if a pop happens that cycle.
  - Capacity is DEPTH queued plus 1 in the output register.
- Flush: takes effect at the next edge. count=0, out_valid=0, pointers reset. Flush dominates a simultaneous push and a simultaneous load. in_ready stays 1.
- Decode is a pure function of the instruction, riscv_pkg::decode(), applied before the output register:
  - RV32I encodings of reg_write, memtoreg, alu_a, alu_b, alu_cntr, branch_cntr, ld_cntr, st_cntr and imm follow the riscv_pkg table.
  - Immediate formats: I/S/SB/U/UJ as standard. Shift immediates are zero-extended shamt[4:0].
  - M-extension (opcode 0110011, funct7 0000001, M_EXT=1): md_op=1, md_funct=funct3, reg_write=1, memtoreg=01, alu_cntr=0000.
- illegal=1 when any of the following holds:
  - unknown opcode;
  - load funct3 outside {000, 001, 010, 100, 101};
  - store funct3 > 010;
  - branch funct3 of 010 or 011;
  - M-type instruction with M_EXT=0;
  - instr[1:0] != 11.
- When illegal=1, reg_write, st_cntr, branch_cntr, jal, jalr, md_op and imm are all 0. out_valid is still asserted so execute can raise the trap.
- No combinational path from out_ready to in_ready. in_ready depends on count only.

Decomposition:
- riscv_pkg holds:
  - opcode, funct3 and funct7 constants;
  - ALU, branch, load and store control code constants;
  - a packed ctrl_t struct;
  - function decode(instr, m_ext) returning ctrl_t.
- Sub-module instr_fifo(DEPTH, W=32+PC_W) provides push, pop, flush, count, full and empty. decode_stage instantiates it and adds the bypass mux and output register.

Test Plan:
- addi x1,x0,5 (0x00500093), out_ready=1 → next cycle out_valid=1, rd=1, reg_write=1, alu_cntr=1000, imm=5, illegal=0.
- beq x1,x2,+8 (0x00208463) → branch_cntr=001, alu_cntr=1100, imm=8, reg_write=0.
- mul x3,x1,x2 (0x022081B3):
  - M_EXT=1 → md_op=1, md_funct=000, rd=3.
  - M_EXT=0 → illegal=1, reg_write=0.
- DEPTH=4, out_ready=0, 6 back-to-back pushes → 5 accepted, in_ready=0 from the cycle after the 5th, count=4. Then out_ready=1 → the 5 instructions emerge in order with no loss or duplication.
- 3 instructions queued, flush=1 together with in_valid=1 → next cycle count=0, out_valid=0, the pushed instruction is dropped, in_ready=1.
- rst asserted with count=3 and out_valid=1 → next cycle all outputs 0, count=0. First push after reset appears 1 cycle later.
